// File: rtl/fifo_ctrl_param.sv
// fifo_ctrl_param: pointer, count and status controller for a single-clock
// FIFO that sits in front of an external dual-port RAM. Port A reads the
// oldest entry and port B writes the next free slot. The status flags are
// registered from the next-state count, so they change on the same edge
// as count. The overflow and underflow flags are sticky.
module fifo_ctrl_param #(
  parameter int ADDR_W     = 10,
  parameter int AFULL_LVL  = (1 << ADDR_W) - 4,
  parameter int AEMPTY_LVL = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              flush,
  input  logic              err_clr,
  input  logic              rd_a_strb,
  input  logic              wr_b_strb,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic              wr_en_b,
  output logic [ADDR_W:0]   count,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              fifo_half,
  output logic              fifo_afull,
  output logic              fifo_aempty,
  output logic              overflow,
  output logic              underflow
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(1 << ADDR_W);
  localparam logic [CNT_W-1:0] HALF_C   = CNT_W'(1 << (ADDR_W - 1));
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_LVL);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_LVL);

  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              half_q, half_d;
  logic              afull_q, afull_d;
  logic              aempty_q, aempty_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              wr_acc, rd_acc;
  logic              ovf_set, udf_set;

  // Accepted strobes and error events, qualified by the registered flags.
  always_comb begin
    wr_acc  = enable & wr_b_strb & ~full_q;
    rd_acc  = enable & rd_a_strb & ~empty_q;
    ovf_set = enable & wr_b_strb & full_q;
    udf_set = enable & rd_a_strb & empty_q;
  end

  // Next-state logic for the pointers, count, flags and sticky errors.
  always_comb begin
    // NOTE: every variable gets a hold value first, so no path through the
    // block leaves one unassigned and no latch is inferred.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    empty_d  = empty_q;
    full_d   = full_q;
    half_d   = half_q;
    afull_d  = afull_q;
    aempty_d = aempty_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (flush) begin
      // Flush discards this cycle's strobes. Every flag except fifo_empty
      // is cleared, including fifo_aempty. fifo_aempty comes back on the
      // next enabled edge.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      empty_d  = 1'b1;
      full_d   = 1'b0;
      half_d   = 1'b0;
      afull_d  = 1'b0;
      aempty_d = 1'b0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      // The pointers wrap naturally because they are ADDR_W bits wide.
      if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_W'(1);

      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase

      // A new error event in the same cycle takes priority over err_clr.
      if (err_clr) begin
        ovf_d = 1'b0;
        udf_d = 1'b0;
      end
      if (ovf_set) ovf_d = 1'b1;
      if (udf_set) udf_d = 1'b1;

      // The flags only move on enabled cycles, so a disabled FIFO is frozen.
      if (enable) begin
        empty_d  = (count_d == '0);
        full_d   = (count_d == DEPTH_C);
        half_d   = (count_d >= HALF_C);
        afull_d  = (count_d >= AFULL_C);
        aempty_d = (count_d <= AEMPTY_C);
      end
    end
  end

  // State registers. Asynchronous reset gives the empty-FIFO state.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state uses non-blocking assignments, so every register samples
    // the values from before the edge and evaluation order cannot matter.
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      half_q   <= 1'b0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      half_q   <= half_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign addr_a      = rd_ptr_q;
  assign addr_b      = wr_ptr_q;
  assign wr_en_b     = wr_acc;
  assign count       = count_q;
  assign fifo_empty  = empty_q;
  assign fifo_full   = full_q;
  assign fifo_half   = half_q;
  assign fifo_afull  = afull_q;
  assign fifo_aempty = aempty_q;
  assign overflow    = ovf_q;
  assign underflow   = udf_q;

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Testbench for fifo_ctrl_param. Two instances share one stimulus stream:
//   d3: ADDR_W=3 with default thresholds (depth 8).
//   d4: ADDR_W=4, AFULL_LVL=12, AEMPTY_LVL=4 (depth 16).
// A reference model tracks occupancy and RAM addresses as plain integers.
module tb_fifo_ctrl_param;

  typedef struct {
    int depth, afull, aempty;
    int cnt, ra, wa;
    bit ovf, udf;
    bit emp, full, half, af, ae;
  } model_t;

  logic clk, reset_n, enable, flush, err_clr, rd_a_strb, wr_b_strb;

  logic [2:0] d3_addr_a, d3_addr_b;
  logic [3:0] d3_count;
  logic d3_wr_en, d3_empty, d3_full, d3_half, d3_afull, d3_aempty, d3_ovf, d3_udf;

  logic [3:0] d4_addr_a, d4_addr_b;
  logic [4:0] d4_count;
  logic d4_wr_en, d4_empty, d4_full, d4_half, d4_afull, d4_aempty, d4_ovf, d4_udf;

  int n_checks = 0;
  int n_pass   = 0;
  model_t m3, m4;

  fifo_ctrl_param #(.ADDR_W(3)) u_d3 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
    .err_clr(err_clr), .rd_a_strb(rd_a_strb), .wr_b_strb(wr_b_strb),
    .addr_a(d3_addr_a), .addr_b(d3_addr_b), .wr_en_b(d3_wr_en),
    .count(d3_count), .fifo_empty(d3_empty), .fifo_full(d3_full),
    .fifo_half(d3_half), .fifo_afull(d3_afull), .fifo_aempty(d3_aempty),
    .overflow(d3_ovf), .underflow(d3_udf)
  );

  fifo_ctrl_param #(.ADDR_W(4), .AFULL_LVL(12), .AEMPTY_LVL(4)) u_d4 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
    .err_clr(err_clr), .rd_a_strb(rd_a_strb), .wr_b_strb(wr_b_strb),
    .addr_a(d4_addr_a), .addr_b(d4_addr_b), .wr_en_b(d4_wr_en),
    .count(d4_count), .fifo_empty(d4_empty), .fifo_full(d4_full),
    .fifo_half(d4_half), .fifo_afull(d4_afull), .fifo_aempty(d4_aempty),
    .overflow(d4_ovf), .underflow(d4_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic model_t model_reset(input model_t m);
    model_t r = m;
    r.cnt = 0; r.ra = 0; r.wa = 0;
    r.ovf = 0; r.udf = 0;
    r.emp = 1; r.full = 0; r.half = 0; r.af = 0; r.ae = 1;
    return r;
  endfunction

  // One rising edge of the FIFO, described by occupancy and addresses.
  function automatic model_t model_step(input model_t m, input bit en, input bit fl,
                                        input bit ec, input bit rd, input bit wr);
    model_t r = m;
    bit is_full, is_empty, w, rdo;
    if (fl) begin
      r.cnt = 0; r.ra = 0; r.wa = 0; r.ovf = 0; r.udf = 0;
      r.emp = 1; r.full = 0; r.half = 0; r.af = 0; r.ae = 0;
    end else begin
      is_full  = (m.cnt == m.depth);
      is_empty = (m.cnt == 0);
      w   = en && wr && !is_full;
      rdo = en && rd && !is_empty;
      if (ec) begin r.ovf = 0; r.udf = 0; end
      if (en && wr && is_full)  r.ovf = 1;
      if (en && rd && is_empty) r.udf = 1;
      if (w)   r.wa = (m.wa + 1) % m.depth;
      if (rdo) r.ra = (m.ra + 1) % m.depth;
      r.cnt = m.cnt + int'(w) - int'(rdo);
      if (en) begin
        r.emp  = (r.cnt == 0);
        r.full = (r.cnt == m.depth);
        r.half = (r.cnt >= m.depth / 2);
        r.af   = (r.cnt >= m.afull);
        r.ae   = (r.cnt <= m.aempty);
      end
    end
    return r;
  endfunction

  task automatic check_all();
    check("d3.addr_a", d3_addr_a, m3.ra);
    check("d3.addr_b", d3_addr_b, m3.wa);
    check("d3.count",  d3_count,  m3.cnt);
    check("d3.flags",  {d3_empty, d3_full, d3_half, d3_afull, d3_aempty},
          {m3.emp, m3.full, m3.half, m3.af, m3.ae});
    check("d3.errors", {d3_ovf, d3_udf}, {m3.ovf, m3.udf});
    check("d4.addr_a", d4_addr_a, m4.ra);
    check("d4.addr_b", d4_addr_b, m4.wa);
    check("d4.count",  d4_count,  m4.cnt);
    check("d4.flags",  {d4_empty, d4_full, d4_half, d4_afull, d4_aempty},
          {m4.emp, m4.full, m4.half, m4.af, m4.ae});
    check("d4.errors", {d4_ovf, d4_udf}, {m4.ovf, m4.udf});
  endtask

  // Apply one cycle of inputs, check the write enable before the edge and all state after it.
  task automatic step(input bit en, input bit fl, input bit ec, input bit rd, input bit wr);
    enable = en; flush = fl; err_clr = ec; rd_a_strb = rd; wr_b_strb = wr;
    #1;
    check("d3.wr_en_b", d3_wr_en, en && wr && (m3.cnt != m3.depth));
    check("d4.wr_en_b", d4_wr_en, en && wr && (m4.cnt != m4.depth));
    @(posedge clk);
    m3 = model_step(m3, en, fl, ec, rd, wr);
    m4 = model_step(m4, en, fl, ec, rd, wr);
    #1;
    check_all();
  endtask

  initial begin
    bit en, fl, ec, rd, wr;
    int wr_pct;
    m3.depth = 8;  m3.afull = 4;  m3.aempty = 4;
    m4.depth = 16; m4.afull = 12; m4.aempty = 4;
    m3 = model_reset(m3);
    m4 = model_reset(m4);
    reset_n = 1'b0;
    enable = 0; flush = 0; err_clr = 0; rd_a_strb = 0; wr_b_strb = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset_n = 1'b1;

    // Fill: d3 fills at 8 and overflows on the 9th write, d4 crosses its thresholds.
    for (int k = 1; k <= 16; k++) begin
      step(1, 0, 0, 0, 1);
      check("fill.d3.count", d3_count, (k < 8) ? k : 8);
      check("fill.d4.aempty", d4_aempty, k <= 4);
      check("fill.d4.half", d4_half, k >= 8);
      check("fill.d4.afull", d4_afull, k >= 12);
      if (k == 8) begin
        check("fill.d3.full", {d3_full, d3_afull, d3_ovf}, 3'b110);
        check("fill.d3.addr_b", d3_addr_b, 0);
      end
      if (k == 9) check("fill.d3.ovf9", {d3_ovf, d3_count}, {1'b1, 4'd8});
    end
    step(1, 0, 0, 0, 1);
    check("fill.d4.ovf", {d4_ovf, d4_full, d4_count}, {1'b1, 1'b1, 5'd16});

    // err_clr alone clears the errors and leaves count unchanged.
    step(1, 0, 1, 0, 0);
    check("errclr.d3", {d3_ovf, d3_count}, {1'b0, 4'd8});
    check("errclr.d4", {d4_ovf, d4_count}, {1'b0, 5'd16});

    // A disabled FIFO ignores both strobes.
    step(0, 0, 0, 1, 1);
    check("disabled.d3.count", d3_count, 8);

    // Drain: d3 empties after 8 reads, then underflows with addr_a held at 0.
    for (int k = 1; k <= 17; k++) begin
      step(1, 0, 0, 1, 0);
      if (k == 8) check("drain.d3.empty", {d3_empty, d3_udf, d3_count, d3_addr_a},
                        {1'b1, 1'b0, 4'd0, 3'd0});
      if (k == 9) check("drain.d3.udf", {d3_udf, d3_addr_a}, {1'b1, 3'd0});
      if (k == 17) check("drain.d4.udf", {d4_empty, d4_udf, d4_addr_a}, {1'b1, 1'b1, 4'd0});
    end

    // Simultaneous read and write at count 3, then full (8), then empty (0).
    step(1, 1, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 1);
    step(1, 0, 0, 1, 1);
    check("simul3.d3", {d3_count, d3_addr_a, d3_addr_b}, {4'd3, 3'd1, 3'd4});
    repeat (5) step(1, 0, 0, 0, 1);
    check("simul8.pre", d3_count, 8);
    step(1, 0, 0, 1, 1);
    check("simul8.d3", d3_count, 7);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 1, 1);
    check("simul0.d3", {d3_count, d3_addr_b, d3_addr_a}, {4'd1, 3'd1, 3'd0});

    // Flush wins over a same-cycle write and clears a pending overflow.
    step(1, 1, 0, 0, 0);
    repeat (9) step(1, 0, 0, 0, 1);
    repeat (3) step(1, 0, 0, 1, 0);
    check("flush.pre", {d3_ovf, d3_count}, {1'b1, 4'd5});
    step(1, 1, 0, 0, 1);
    check("flush.d3", {d3_count, d3_ovf, d3_addr_b}, {4'd0, 1'b0, 3'd0});

    // Randomized traffic in phases that lean toward filling or draining.
    for (int i = 0; i < 3000; i++) begin
      wr_pct = ((i / 150) % 2 == 0) ? 70 : 30;
      en = ($urandom % 8) != 0;
      fl = ($urandom % 97) == 0;
      ec = ($urandom % 41) == 0;
      wr = ($urandom % 100) < wr_pct;
      rd = ($urandom % 100) < (100 - wr_pct);
      step(en, fl, ec, rd, wr);
    end

    // Asynchronous reset between edges at count 6, with a write strobe pending.
    step(1, 1, 0, 0, 0);
    repeat (6) step(1, 0, 0, 0, 1);
    check("areset.pre", d3_count, 6);
    wr_b_strb = 1'b1;
    #2;
    reset_n = 1'b0;
    m3 = model_reset(m3);
    m4 = model_reset(m4);
    #1;
    check_all();
    check("areset.d3", {d3_count, d3_empty, d3_aempty, d3_addr_b}, {4'd0, 1'b1, 1'b1, 3'd0});
    @(posedge clk);
    #1;
    check_all();
    reset_n = 1'b1;
    step(1, 0, 0, 0, 1);
    check("areset.resume", d3_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl_param.md
FIFO_CTRL_PARAM -- requirements
Module: fifo_ctrl_param

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, the address width; depth DEPTH = 2^ADDR_W entries.
REQ-002 SHALL have parameter AFULL_LVL, default 2^ADDR_W - 4, the almost-full threshold in entries.
REQ-003 SHALL have parameter AEMPTY_LVL, default 4, the almost-empty threshold in entries.
REQ-004 SHALL have port clk  input  1  system clock; all state changes occur on the rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  when low, read and write strobes are ignored and no state changes.
REQ-007 SHALL have port flush  input  1  synchronous clear of pointers, count and error flags.
REQ-008 SHALL have port err_clr  input  1  synchronous clear of the sticky error flags only.
REQ-009 SHALL have port rd_a_strb  input  1  read request; pops one entry.
REQ-010 SHALL have port wr_b_strb  input  1  write request; pushes one entry.
REQ-011 SHALL have port addr_a  output  ADDR_W  RAM read address, pointing at the oldest entry.
REQ-012 SHALL have port addr_b  output  ADDR_W  RAM write address, pointing at the next free slot.
REQ-013 SHALL have port wr_en_b  output  1  combinational RAM write enable, equal to the accepted write.
REQ-014 SHALL have port count  output  ADDR_W+1  number of stored entries, range 0..DEPTH.
REQ-015 SHALL have ports fifo_empty, fifo_full, fifo_half, fifo_afull, fifo_aempty  output  1 each  status flags.
REQ-016 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 SHALL define wr_acc = enable & wr_b_strb & ~fifo_full and rd_acc = enable & rd_a_strb & ~fifo_empty.
REQ-018 SHALL increment addr_b by 1 on wr_acc, wrapping modulo DEPTH from DEPTH-1 to 0.
REQ-019 SHALL increment addr_a by 1 on rd_acc, wrapping modulo DEPTH from DEPTH-1 to 0.
REQ-020 SHALL update count as: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither are accepted.
REQ-021 SHALL reject a write while full even if a read is accepted in the same cycle; the read proceeds and count decrements.
REQ-022 SHALL reject a read while empty even if a write is accepted in the same cycle; the write proceeds and count increments.
REQ-023 SHALL register all flags from the next-state count, so flags and count change on the same edge with no extra cycle of latency.
REQ-024 SHALL set the flags as follows: fifo_empty when count==0; fifo_full when count==DEPTH; fifo_half when count>=DEPTH/2; fifo_afull when count>=AFULL_LVL; fifo_aempty when count<=AEMPTY_LVL.
REQ-025 SHALL set overflow on the edge after enable & wr_b_strb & fifo_full, and hold it until err_clr, flush or reset.
REQ-026 SHALL set underflow on the edge after enable & rd_a_strb & fifo_empty, and hold it until err_clr, flush or reset.
REQ-027 SHALL let a new error set take priority over err_clr when both occur in the same cycle.
REQ-028 SHALL give flush priority over all strobes: pointers=0, count=0, fifo_empty=1, other flags=0, errors=0; the strobes in that cycle are discarded.
REQ-029 SHALL leave all state unchanged while enable is low, except for the effects of flush and err_clr.
REQ-030 SHALL hold addr_a==addr_b whenever count is 0 or DEPTH.

Reset
REQ-031 SHALL, while reset_n is low and regardless of clk, force addr_a=0, addr_b=0, count=0, fifo_empty=1, fifo_aempty=1, fifo_full=0, fifo_half=0, fifo_afull=0, overflow=0, underflow=0.
REQ-032 SHALL return to the REQ-031 state on reset assertion mid-operation, discarding any in-flight strobe, and resume normal operation on the first rising edge after deassertion.

Verification
REQ-033 SHALL cover the fill test: ADDR_W=3, write 8 times -> count=8, fifo_full=1, fifo_afull=1, addr_b=0; a 9th write -> overflow=1 and count remains 8.
REQ-034 SHALL cover the drain test: from full, read 8 times -> count=0, fifo_empty=1, addr_a=0; a 9th read -> underflow=1 and addr_a remains 0.
REQ-035 SHALL cover simultaneous strobes: count=3 with read and write together -> count stays 3 and both pointers advance; at count=8 together -> only the read is accepted and count=7; at count=0 together -> only the write is accepted and count=1.
REQ-036 SHALL cover the thresholds: ADDR_W=4, AFULL_LVL=12, AEMPTY_LVL=4 -> fifo_aempty falls at count 5, fifo_half rises at 8, fifo_afull rises at 12, each on the same edge count changes.
REQ-037 SHALL cover flush and err_clr: with overflow=1 and count=5, flush plus a write in the same cycle -> count=0, overflow=0, addr_b=0; err_clr alone clears the errors but leaves count unchanged.
REQ-038 SHALL cover asynchronous reset: assert reset_n low between edges at count=6 -> outputs reach their reset values immediately, without waiting for clk.
